// File: rtl/wb_rom_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the instruction ROM.
// The grant is held for the whole cyc. A per-access watchdog errors a stalled strobe.
module wb_rom_arbiter #(
   parameter int aw      = 32,
   parameter int dw      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [aw-1:0] m0_adr_i,
   input  logic [dw-1:0] m0_dat_i,
   input  logic [3:0]    m0_sel_i,
   input  logic          m0_we_i,
   input  logic          m0_stb_i,
   input  logic          m0_cyc_i,
   output logic [dw-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [aw-1:0] m1_adr_i,
   input  logic [dw-1:0] m1_dat_i,
   input  logic [3:0]    m1_sel_i,
   input  logic          m1_we_i,
   input  logic          m1_stb_i,
   input  logic          m1_cyc_i,
   output logic [dw-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [aw-1:0] s_adr_o,
   output logic [dw-1:0] s_dat_o,
   output logic [3:0]    s_sel_o,
   output logic          s_we_o,
   output logic          s_stb_o,
   output logic          s_cyc_o,
   input  logic [dw-1:0] s_dat_i,
   input  logic          s_ack_i
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t     state, state_nxt;
   logic       last, last_nxt;
   logic [7:0] wdog;
   logic       req0, req1, timeout;

   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      s_adr_o   = '0;
      s_dat_o   = '0;
      s_sel_o   = '0;
      s_we_o    = 1'b0;
      s_stb_o   = 1'b0;
      s_cyc_o   = 1'b0;
      case (state)
         IDLE: begin
            // On a tie the master that was not served last wins
            if (req0 && (!req1 || last)) begin
               state_nxt = GNT0;
               last_nxt  = 1'b0;
            end else if (req1) begin
               state_nxt = GNT1;
               last_nxt  = 1'b1;
            end
         end
         GNT0: begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & m0_cyc_i;
            if (!m0_cyc_i) state_nxt = IDLE;
         end
         GNT1: begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & m1_cyc_i;
            if (!m1_cyc_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // s_stb_o is already zero outside a grant, so it doubles as "granted strobe"
   assign timeout = s_stb_o & ~s_ack_i & (wdog == 8'(TIMEOUT - 1));

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_ack_o = s_ack_i & (state == GNT0) & m0_stb_i;
   assign m1_ack_o = s_ack_i & (state == GNT1) & m1_stb_i;
   assign m0_err_o = timeout & (state == GNT0);
   assign m1_err_o = timeout & (state == GNT1);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= IDLE;
         last  <= 1'b1;
         wdog  <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         wdog  <= (s_stb_o && !s_ack_i && !timeout) ? wdog + 8'd1 : 8'd0;
      end
   end

endmodule

// File: tb/tb_wb_rom_arbiter.sv
// Directed bench for wb_rom_arbiter: reset, single read, ties, round-robin,
// burst hold, watchdog timeout and mid-transfer reset.
module tb_wb_rom_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [AW-1:0] A0 = 32'h0000_0100;
   localparam logic [AW-1:0] A1 = 32'h0000_0200;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] m0_adr, m1_adr, s_adr;
   logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat, s_rdat;
   logic [3:0]    m0_sel, m1_sel, s_sel;
   logic          m0_we, m0_stb, m0_cyc, m0_ack, m0_err;
   logic          m1_we, m1_stb, m1_cyc, m1_ack, m1_err;
   logic          s_we, s_stb, s_cyc, s_ack;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   wb_rom_arbiter #(.aw(AW), .dw(DW), .TIMEOUT(16)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
      .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_dat_i(s_rdat), .s_ack_i(s_ack)
   );

   // Advance to just after the next rising edge; inputs are driven and outputs sampled here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m0_adr = A0; m0_wdat = 32'h1111_0000; m0_sel = 4'hf; m0_we = 1'b0;
      m1_adr = A1; m1_wdat = 32'h2222_0000; m1_sel = 4'h3; m1_we = 1'b1;
      m0_stb = 1'b0; m0_cyc = 1'b0; m1_stb = 1'b0; m1_cyc = 1'b0;
      s_ack = 1'b0; s_rdat = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_chk++;
      if ({s_adr, s_wdat, s_sel, s_we, s_stb, s_cyc} !== '0) begin
         n_fail++;
         $display("FAIL reset_s_outputs: got adr=%h dat=%h sel=%h we=%b stb=%b cyc=%b, want all 0",
                  s_adr, s_wdat, s_sel, s_we, s_stb, s_cyc);
      end
      n_chk++;
      if ({m0_ack, m0_err, m1_ack, m1_err, m0_rdat, m1_rdat} !== '0) begin
         n_fail++;
         $display("FAIL reset_m_outputs: got ack=%b%b err=%b%b dat=%h/%h, want all 0",
                  m0_ack, m1_ack, m0_err, m1_err, m0_rdat, m1_rdat);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      m0_adr = 32'h10; m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      n_chk++;
      if (s_cyc !== 1'b0) begin
         n_fail++; $display("FAIL single_latency0: s_cyc=%b want 0", s_cyc);
      end
      tick();
      n_chk++;
      if (s_cyc !== 1'b1 || s_stb !== 1'b1 || s_adr !== 32'h10 || s_sel !== 4'hf) begin
         n_fail++;
         $display("FAIL single_grant: cyc=%b stb=%b adr=%h sel=%h want 1 1 00000010 f",
                  s_cyc, s_stb, s_adr, s_sel);
      end
      tick(); tick(); tick();
      s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
      #1;
      n_chk++;
      if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEAD_BEEF || m1_ack !== 1'b0 || m0_err !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ack: m0_ack=%b m0_dat=%h m1_ack=%b err=%b want 1 deadbeef 0 0",
                  m0_ack, m0_rdat, m1_ack, m0_err);
      end
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      n_chk++;
      if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
         n_fail++; $display("FAIL single_release: s_cyc=%b m0_ack=%b want 0 0", s_cyc, m0_ack);
      end
   endtask

   task automatic test_tie();
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      n_chk++;
      if (s_adr !== A0 || s_cyc !== 1'b1) begin
         n_fail++; $display("FAIL tie_first: adr=%h cyc=%b want %h 1", s_adr, s_cyc, A0);
      end
      s_ack = 1'b1;
      #1;
      n_chk++;
      if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
         n_fail++; $display("FAIL tie_ack: m0_ack=%b m1_ack=%b want 1 0", m0_ack, m1_ack);
      end
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      n_chk++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
         n_fail++; $display("FAIL tie_drop_same_cycle: cyc=%b stb=%b want 0 0", s_cyc, s_stb);
      end
      tick();
      n_chk++;
      if (s_cyc !== 1'b0) begin
         n_fail++; $display("FAIL tie_idle_gap: s_cyc=%b want 0", s_cyc);
      end
      tick();
      n_chk++;
      if (s_adr !== A1 || s_cyc !== 1'b1 || s_we !== 1'b1 || s_sel !== 4'h3) begin
         n_fail++;
         $display("FAIL tie_second: adr=%h cyc=%b we=%b sel=%h want %h 1 1 3", s_adr, s_cyc, s_we, s_sel, A1);
      end
   endtask

   task automatic test_round_robin();
      int wait_cyc;
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wait_cyc = 0;
         while (s_cyc !== 1'b1 && wait_cyc < 5) begin
            tick();
            wait_cyc++;
         end
         n_chk++;
         if (s_cyc !== 1'b1 || s_adr !== ((i % 2) ? A1 : A0)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: cyc=%b adr=%h want 1 %h", i, s_cyc, s_adr, (i % 2) ? A1 : A0);
         end
         s_ack = 1'b1;
         #1;
         n_chk++;
         if ({m0_ack, m1_ack} !== ((i % 2) ? 2'b01 : 2'b10)) begin
            n_fail++;
            $display("FAIL rr_ack%0d: m0_ack=%b m1_ack=%b", i, m0_ack, m1_ack);
         end
         tick();
         s_ack = 1'b0;
         if (i % 2) begin m1_cyc = 1'b0; m1_stb = 1'b0; end
         else       begin m0_cyc = 1'b0; m0_stb = 1'b0; end
         tick();
         m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int acks;
      acks = 0;
      do_reset();
      m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      m0_cyc = 1'b1; m0_stb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         m1_adr = A1 + 32'(4 * i);
         s_ack = 1'b1;
         #1;
         if (m1_ack === 1'b1) acks++;
         n_chk++;
         if (m0_ack !== 1'b0 || s_adr !== A1 + 32'(4 * i)) begin
            n_fail++; $display("FAIL burst_hold%0d: m0_ack=%b adr=%h", i, m0_ack, s_adr);
         end
         tick();
         s_ack = 1'b0;
         tick();
      end
      n_chk++;
      if (acks !== 3) begin
         n_fail++; $display("FAIL burst_acks: got %0d m1 acks want 3", acks);
      end
      m1_cyc = 1'b0; m1_stb = 1'b0;
      tick();
      tick();
      n_chk++;
      if (s_adr !== A0 || s_cyc !== 1'b1) begin
         n_fail++; $display("FAIL burst_handover: adr=%h cyc=%b want %h 1", s_adr, s_cyc, A0);
      end
   endtask

   task automatic test_timeout();
      int errs;
      errs = 0;
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      // s_stb_o rises here; err belongs in the 16th cycle of the stalled strobe
      for (int k = 0; k < 16; k++) begin
         if (m0_err === 1'b1) errs++;
         n_chk++;
         if (m0_err !== (k == 15) || m0_ack !== 1'b0 || m1_err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_k%0d: m0_err=%b m0_ack=%b m1_err=%b want %b 0 0", k, m0_err, m0_ack, m1_err, k == 15);
         end
         if (k < 15) tick();
      end
      n_chk++;
      if (errs !== 1) begin
         n_fail++; $display("FAIL timeout_pulses: got %0d want 1", errs);
      end
      tick();
      n_chk++;
      if (m0_err !== 1'b0 || s_cyc !== 1'b1) begin
         n_fail++; $display("FAIL timeout_no_release: err=%b cyc=%b want 0 1", m0_err, s_cyc);
      end
      m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
      tick();
      n_chk++;
      if (s_cyc !== 1'b0 || m0_err !== 1'b0) begin
         n_fail++; $display("FAIL timeout_idle: cyc=%b err=%b want 0 0", s_cyc, m0_err);
      end
   endtask

   task automatic test_ack_beats_timeout();
      do_reset();
      m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      for (int k = 0; k < 15; k++) tick();
      s_ack = 1'b1;
      #1;
      n_chk++;
      if (m0_err !== 1'b0 || m0_ack !== 1'b1) begin
         n_fail++; $display("FAIL ack_wins: err=%b ack=%b want 0 1", m0_err, m0_ack);
      end
      tick();
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_cyc = 1'b1; m1_stb = 1'b1;
      tick();
      n_chk++;
      if (s_cyc !== 1'b1 || s_adr !== A1) begin
         n_fail++; $display("FAIL rstmid_grant: cyc=%b adr=%h want 1 %h", s_cyc, s_adr, A1);
      end
      rst = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
      tick();
      s_ack = 1'b1;
      #1;
      n_chk++;
      if ({s_adr, s_wdat, s_sel, s_we, s_stb, s_cyc} !== '0 || m1_ack !== 1'b0 || m0_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: adr=%h stb=%b cyc=%b m1_ack=%b m0_ack=%b want all 0",
                  s_adr, s_stb, s_cyc, m1_ack, m0_ack);
      end
      rst = 1'b0; s_ack = 1'b0;
      tick();
      n_chk++;
      if (s_adr !== A0 || s_cyc !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_tie: adr=%h cyc=%b want %h 1", s_adr, s_cyc, A0);
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_tie();
      test_round_robin();
      test_back_to_back();
      test_timeout();
      test_ack_beats_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
